regfile_p: RTL and testbench

REGFILE_P -- requirements
Module: regfile_p

---
 rtl/regfile_p_if.sv | 26 ++
 rtl/regfile_p.sv | 86 ++++++++
 tb/tb_regfile_p.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/regfile_p_if.sv
// Bus bundle for the regfile_p register file: one write port, two read ports,
// plus the ready and rejected-write status flags.
interface regfile_p_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] di;
  logic [AW-1:0] ra0;
  logic [AW-1:0] ra1;
  logic [DW-1:0] do0;
  logic [DW-1:0] do1;
  logic          ready;
  logic          wr_err;

  modport master (
    output we, wa, di, ra0, ra1,
    input  do0, do1, ready, wr_err
  );

  modport slave (
    input  we, wa, di, ra0, ra1,
    output do0, do1, ready, wr_err
  );
endinterface

// File: rtl/regfile_p.sv
// Register file with write-protected constant entries and a power-up loader.
// Optional same-cycle write-to-read forwarding is enabled by REGFILE_P_BYPASS_EN.
module regfile_p #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int WR_LIMIT = 4,
  parameter logic [(2**AW)*DW-1:0] INIT = 128'h0000_0000_00FE_FCFA_00FF_01FE_FF41_0302
) (
  input logic     clk,
  input logic     rst,
  regfile_p_if.slave bus
);
  localparam int DEPTH = 2**AW;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          wrErr_q, wrErr_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic wrInRange;
  logic wrAccept;
  logic wrReject;
  logic byp0;
  logic byp1;

  assign wrInRange = (int'(bus.wa) < WR_LIMIT);
  assign wrAccept  = bus.we && ready_q && wrInRange;
  assign wrReject  = bus.we && !(ready_q && wrInRange);

  // The loader walks every entry once, then parks on the last index for good.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    wrErr_d = wrReject;
    if (state_q == S_INIT) begin
      if (cnt_q == {AW{1'b1}}) begin
        state_d = S_RUN;
        ready_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      wrErr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      wrErr_q <= wrErr_d;
    end
  end

  // Storage has no reset; a reset only restarts the loader, which then rewrites every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_INIT) begin
        mem_q[cnt_q] <= INIT[cnt_q*DW +: DW];
      end else if (wrAccept) begin
        mem_q[bus.wa] <= bus.di;
      end
    end
  end

`ifdef REGFILE_P_BYPASS_EN
  assign byp0 = wrAccept && (bus.wa == bus.ra0);
  assign byp1 = wrAccept && (bus.wa == bus.ra1);
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif

  assign bus.do0    = !ready_q ? '0 : (byp0 ? bus.di : mem_q[bus.ra0]);
  assign bus.do1    = !ready_q ? '0 : (byp1 ? bus.di : mem_q[bus.ra1]);
  assign bus.ready  = ready_q;
  assign bus.wr_err = wrErr_q;
endmodule

// File: tb/tb_regfile_p.sv
// Self-checking bench for regfile_p: directed scenarios followed by random
// traffic, all compared against a behavioural model of the register file.
module tb_regfile_p;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int WR_LIMIT = 4;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  logic [7:0] initVals [DEPTH];
  logic [7:0] refMem [DEPTH];
  int         refLoaded;
  logic       refReady;
  logic       refErr;

  regfile_p_if #(.DW(DW), .AW(AW)) bus ();

  regfile_p dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] expectedRead(input logic [3:0] ra);
    logic bypass;
`ifdef REGFILE_P_BYPASS_EN
    bypass = refReady && bus.we && (int'(bus.wa) < WR_LIMIT) && (bus.wa == ra);
`else
    bypass = 1'b0;
`endif
    if (!refReady) return 8'h00;
    if (bypass) return bus.di;
    return refMem[ra];
  endfunction

  // The model follows the behavioural rules: a reset forgets everything, then the
  // loader copies one constant per cycle and opens for writes after the last one.
  task automatic modelEdge();
    if (rst) begin
      refLoaded = 0;
      refReady  = 1'b0;
      refErr    = 1'b0;
    end else if (!refReady) begin
      refMem[refLoaded] = initVals[refLoaded];
      refLoaded++;
      if (refLoaded == DEPTH) refReady = 1'b1;
      refErr = bus.we;
    end else begin
      refErr = bus.we && (int'(bus.wa) >= WR_LIMIT);
      if (bus.we && int'(bus.wa) < WR_LIMIT) refMem[bus.wa] = bus.di;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d,
                               input logic [3:0] r0, input logic [3:0] r1);
    rst     = r;
    bus.we  = w;
    bus.wa  = a;
    bus.di  = d;
    bus.ra0 = r0;
    bus.ra1 = r1;
    @(negedge clk);
    checkOutput("ready", 32'(bus.ready), 32'(refReady));
    checkOutput("wr_err", 32'(bus.wr_err), 32'(refErr));
    checkOutput("do0", 32'(bus.do0), 32'(expectedRead(r0)));
    checkOutput("do1", 32'(bus.do1), 32'(expectedRead(r1)));
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 4'(i), 4'(i + 5));
  endtask

  initial begin
    logic [7:0] wasReady;
    initVals = '{8'h02, 8'h03, 8'h41, 8'hFF, 8'hFE, 8'h01, 8'hFF, 8'h00,
                 8'hFA, 8'hFC, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    foreach (refMem[i]) refMem[i] = 8'h00;
    compared   = 0;
    mismatched = 0;
    refLoaded  = 0;
    refReady   = 1'b0;
    refErr     = 1'b0;

    rst = 1'b1;
    bus.we = 1'b0; bus.wa = '0; bus.di = '0; bus.ra0 = '0; bus.ra1 = '0;
    @(posedge clk);
    #1;

    // Power-up load, with a write attempted in the third cycle after release.
    applyStimulus(1'b1, 1'b0, 4'h0, 8'h00, 4'h0, 4'h1);
    idle(2);
    applyStimulus(1'b0, 1'b1, 4'h1, 8'hAA, 4'h1, 4'h1);
    idle(13);
    checkOutput("ready_after_16", 32'(bus.ready), 32'd1);
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 4'(i), 4'(10 - i));

    // Accepted write, protected write, then a check that the error pulse is single.
    applyStimulus(1'b0, 1'b1, 4'h2, 8'h5A, 4'h2, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 4'h2, 4'h0);
    checkOutput("entry2_written", 32'(bus.do0), 32'h5A);
    applyStimulus(1'b0, 1'b1, 4'h5, 8'h77, 4'h5, 4'h5);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 4'h5, 4'h5);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 4'h5, 4'h4);
    applyStimulus(1'b0, 1'b1, 4'h3, 8'hEE, 4'h3, 4'h3);

    // Reset after running must reload every entry, including written ones.
    applyStimulus(1'b0, 1'b1, 4'h3, 8'h80, 4'h3, 4'h3);
    idle(5);
    applyStimulus(1'b1, 1'b1, 4'h0, 8'h11, 4'h3, 4'h0);
    idle(16);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 4'h3, 4'h2);
    checkOutput("entry3_restored", 32'(bus.do0), 32'hFF);

    // Same-cycle forwarding case; the model decides the expected value per build.
    applyStimulus(1'b0, 1'b1, 4'h0, 8'hC3, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 4'h1);
    checkOutput("entry0_written", 32'(bus.do0), 32'hC3);

    // Random traffic, with occasional resets and writes aimed at both regions.
    wasReady = 8'h0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0),
                    4'($urandom_range(0, 7)), 8'($urandom), 4'($urandom), 4'($urandom));
      if (refReady) wasReady = wasReady + 8'h1;
    end
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 4'(i), 4'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
